// File: rtl/adc_max10_pkg.sv
// Shared widths, register map, ADCS field positions and sequencer state
// encoding for the MAX10 ADC controller.
package adc_max10_pkg;

   localparam int ADC_ADDR_WIDTH = 4;
   localparam int ADC_CELL_COUNT = 8;

   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADC0  = 4'h0;
   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADC1  = 4'h1;
   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADC2  = 4'h2;
   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADC3  = 4'h3;
   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADC4  = 4'h4;
   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADC5  = 4'h5;
   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADC6  = 4'h6;
   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADC7  = 4'h7;
   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADCS  = 4'h8;
   localparam logic [ADC_ADDR_WIDTH-1:0] ADC_REG_ADMSK = 4'h9;

   localparam int ADC_FIELD_ADCS_EN = 0;
   localparam int ADC_FIELD_ADCS_SC = 1;
   localparam int ADC_FIELD_ADCS_TE = 2;
   localparam int ADC_FIELD_ADCS_FR = 3;
   localparam int ADC_FIELD_ADCS_IF = 4;
   localparam int ADC_FIELD_ADCS_IE = 5;

   localparam logic [2:0] ADC_CELL_0 = 3'd0;
   localparam logic [2:0] ADC_CELL_1 = 3'd1;
   localparam logic [2:0] ADC_CELL_2 = 3'd2;
   localparam logic [2:0] ADC_CELL_3 = 3'd3;
   localparam logic [2:0] ADC_CELL_4 = 3'd4;
   localparam logic [2:0] ADC_CELL_5 = 3'd5;
   localparam logic [2:0] ADC_CELL_6 = 3'd6;
   localparam logic [2:0] ADC_CELL_7 = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } adc_state_t;

endpackage

// File: rtl/adc_max10_chan_sel.sv
// Picks the lowest pending cell from the remaining-mask and tells whether
// it is the final one of the sequence.
module adc_max10_chan_sel
   import adc_max10_pkg::*;
(
   input  logic [ADC_CELL_COUNT-1:0] mask,
   output logic [2:0]                index,
   output logic                      found,
   output logic                      last
);

   always_comb begin
      index = '0;
      // Descending scan so the lowest set bit is the one that sticks.
      for (int i = ADC_CELL_COUNT - 1; i >= 0; i--) begin
         if (mask[i]) index = 3'(i);
      end
   end

   assign found = |mask;
   // Clearing the lowest set bit leaves nothing only when one bit remains.
   assign last  = found && ((mask & (mask - 1'b1)) == '0);

endmodule

// File: rtl/adc_max10_ctrl.sv
// Register-mapped sequencer driving the MAX10 modular ADC Avalon-ST command
// port and capturing each response into a per-cell data register.
module adc_max10_ctrl
   import adc_max10_pkg::*;
(
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [ADC_ADDR_WIDTH-1:0] read_addr,
   output logic [31:0]               read_data,
   input  logic [ADC_ADDR_WIDTH-1:0] write_addr,
   input  logic [31:0]               write_data,
   input  logic                      write_enable,
   output logic                      ADC_C_Valid,
   output logic [4:0]                ADC_C_Channel,
   output logic                      ADC_C_SOP,
   output logic                      ADC_C_EOP,
   input  logic                      ADC_C_Ready,
   input  logic                      ADC_R_Valid,
   input  logic [4:0]                ADC_R_Channel,
   input  logic [11:0]               ADC_R_Data,
   input  logic                      ADC_R_SOP,
   input  logic                      ADC_R_EOP,
   input  logic                      ADC_Trigger,
   output logic                      ADC_Interrupt
);

   logic [11:0]               data_reg [ADC_CELL_COUNT];
   logic [ADC_CELL_COUNT-1:0] admsk;
   logic [ADC_CELL_COUNT-1:0] remaining;
   logic                      en, sc, te, fr, if_flag, ie;
   logic                      first;
   logic [2:0]                trig_sync;
   adc_state_t                state;

   logic [2:0] sel_index;
   logic       sel_found, sel_last;
   logic       adcs_wr, start_sw, start_trig, abort;
   logic       unused_inputs;

   adc_max10_chan_sel u_chan_sel (
      .mask  (remaining),
      .index (sel_index),
      .found (sel_found),
      .last  (sel_last)
   );

   assign adcs_wr    = write_enable && (write_addr == ADC_REG_ADCS);
   assign start_sw   = adcs_wr && write_data[ADC_FIELD_ADCS_SC] &&
                       write_data[ADC_FIELD_ADCS_EN] && (state == ST_IDLE);
   assign start_trig = trig_sync[1] && !trig_sync[2] && en && te &&
                       (state == ST_IDLE);
   assign abort      = adcs_wr && !write_data[ADC_FIELD_ADCS_EN];

   assign ADC_Interrupt = if_flag & ie;
   assign unused_inputs = ^{ADC_R_Channel, ADC_R_SOP, ADC_R_EOP, write_data[31:8]};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         // NOTE: the result cells are software-visible and must read 0 after
         // reset, so this small array is reset like any other register.
         for (int i = 0; i < ADC_CELL_COUNT; i++) data_reg[i] <= '0;
         admsk         <= '0;
         remaining     <= '0;
         {en, sc, te, fr, if_flag, ie} <= '0;
         first         <= 1'b0;
         trig_sync     <= '0;
         state         <= ST_IDLE;
         ADC_C_Valid   <= 1'b0;
         ADC_C_Channel <= '0;
         ADC_C_SOP     <= 1'b0;
         ADC_C_EOP     <= 1'b0;
      end else begin
         trig_sync <= {trig_sync[1:0], ADC_Trigger};

         if (write_enable && (write_addr == ADC_REG_ADMSK)) admsk <= write_data[7:0];
         if (adcs_wr) begin
            en <= write_data[ADC_FIELD_ADCS_EN];
            te <= write_data[ADC_FIELD_ADCS_TE];
            fr <= write_data[ADC_FIELD_ADCS_FR];
            ie <= write_data[ADC_FIELD_ADCS_IE];
         end

         // A completion setting IF outranks a simultaneous write-one-to-clear.
         if (state == ST_DONE) if_flag <= 1'b1;
         else if (adcs_wr && write_data[ADC_FIELD_ADCS_IF]) if_flag <= 1'b0;

         case (state)
            ST_IDLE: ;
            ST_CMD: begin
               if (!ADC_C_Valid) begin
                  if (sel_found) begin
                     ADC_C_Valid   <= 1'b1;
                     ADC_C_Channel <= {2'b00, sel_index};
                     ADC_C_SOP     <= first;
                     ADC_C_EOP     <= sel_last;
                     first         <= 1'b0;
                  end else begin
                     sc    <= 1'b0;
                     state <= ST_IDLE;
                  end
               end else if (ADC_C_Ready) begin
                  ADC_C_Valid <= 1'b0;
                  ADC_C_SOP   <= 1'b0;
                  ADC_C_EOP   <= 1'b0;
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (ADC_R_Valid) begin
                  data_reg[ADC_C_Channel[2:0]] <= ADC_R_Data;
                  remaining <= remaining & ~(8'b1 << ADC_C_Channel[2:0]);
                  state     <= sel_last ? ST_DONE : ST_CMD;
               end
            end
            ST_DONE: begin
               if (fr && en) begin
                  remaining <= admsk;
                  first     <= 1'b1;
                  state     <= ST_CMD;
               end else begin
                  sc    <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (start_sw || start_trig) begin
            remaining <= admsk;
            first     <= 1'b1;
            sc        <= 1'b1;
            state     <= ST_CMD;
         end

         if (abort) begin
            sc          <= 1'b0;
            state       <= ST_IDLE;
            ADC_C_Valid <= 1'b0;
            ADC_C_SOP   <= 1'b0;
            ADC_C_EOP   <= 1'b0;
         end
      end
   end

   always_comb begin
      read_data = '0;
      if (read_addr < ADC_ADDR_WIDTH'(ADC_CELL_COUNT))
         read_data = {20'b0, data_reg[read_addr[2:0]]};
      else if (read_addr == ADC_REG_ADCS)
         read_data = {26'b0, ie, if_flag, fr, te, sc, en};
      else if (read_addr == ADC_REG_ADMSK)
         read_data = {24'b0, admsk};
   end

endmodule

// File: tb/tb_adc_max10_ctrl.sv
// Directed bench for adc_max10_ctrl: software start, trigger start,
// free-running, abort and reset, with hand-computed expectations.
module tb_adc_max10_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  read_addr;
   logic [31:0] read_data;
   logic [3:0]  write_addr;
   logic [31:0] write_data;
   logic        write_enable;
   logic        ADC_C_Valid;
   logic [4:0]  ADC_C_Channel;
   logic        ADC_C_SOP;
   logic        ADC_C_EOP;
   logic        ADC_C_Ready;
   logic        ADC_R_Valid;
   logic [4:0]  ADC_R_Channel;
   logic [11:0] ADC_R_Data;
   logic        ADC_R_SOP;
   logic        ADC_R_EOP;
   logic        ADC_Trigger;
   logic        ADC_Interrupt;

   int total = 0;
   int bad   = 0;

   adc_max10_ctrl dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .read_addr     (read_addr),
      .read_data     (read_data),
      .write_addr    (write_addr),
      .write_data    (write_data),
      .write_enable  (write_enable),
      .ADC_C_Valid   (ADC_C_Valid),
      .ADC_C_Channel (ADC_C_Channel),
      .ADC_C_SOP     (ADC_C_SOP),
      .ADC_C_EOP     (ADC_C_EOP),
      .ADC_C_Ready   (ADC_C_Ready),
      .ADC_R_Valid   (ADC_R_Valid),
      .ADC_R_Channel (ADC_R_Channel),
      .ADC_R_Data    (ADC_R_Data),
      .ADC_R_SOP     (ADC_R_SOP),
      .ADC_R_EOP     (ADC_R_EOP),
      .ADC_Trigger   (ADC_Trigger),
      .ADC_Interrupt (ADC_Interrupt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      write_addr   = a;
      write_data   = d;
      write_enable = 1'b1;
      @(negedge CLK);
      write_enable = 1'b0;
   endtask

   task automatic rd_check(input logic [3:0] a, input logic [31:0] exp, input string tag);
      read_addr = a;
      #1;
      check(tag, read_data, exp);
   endtask

   // Waits (bounded) for a command, checks its fields, optionally accepts it.
   task automatic wait_cmd(input logic [4:0] ch, input logic sop, input logic eop,
                           input bit accept, input string tag);
      int n = 0;
      while (ADC_C_Valid !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_valid"}, 32'(ADC_C_Valid), 32'd1);
      check({tag, "_ch"},    32'(ADC_C_Channel), 32'(ch));
      check({tag, "_sop"},   32'(ADC_C_SOP), 32'(sop));
      check({tag, "_eop"},   32'(ADC_C_EOP), 32'(eop));
      if (accept) begin
         ADC_C_Ready = 1'b1;
         @(negedge CLK);
         ADC_C_Ready = 1'b0;
      end
   endtask

   task automatic respond(input logic [11:0] d);
      ADC_R_Valid = 1'b1;
      ADC_R_Data  = d;
      @(negedge CLK);
      ADC_R_Valid = 1'b0;
   endtask

   initial begin
      int vcount;
      RESET = 1'b1; read_addr = '0; write_addr = '0; write_data = '0;
      write_enable = 1'b0; ADC_C_Ready = 1'b0; ADC_R_Valid = 1'b0;
      ADC_R_Channel = '0; ADC_R_Data = '0; ADC_R_SOP = 1'b0; ADC_R_EOP = 1'b0;
      ADC_Trigger = 1'b0;
      repeat (2) @(negedge CLK);
      rd_check(4'h8, 32'h0, "rst_adcs");
      check("rst_valid", 32'(ADC_C_Valid), 32'd0);
      check("rst_irq", 32'(ADC_Interrupt), 32'd0);
      RESET = 1'b0;
      @(negedge CLK);

      // Single-cell software start on channel 1.
      wr(4'h9, 32'h02);
      wr(4'h8, 32'h27);
      wait_cmd(5'd1, 1'b1, 1'b1, 1'b1, "sw1");
      respond(12'hABC);
      @(negedge CLK);
      rd_check(4'h1, 32'h00000ABC, "sw1_adc1");
      rd_check(4'h8, 32'h35, "sw1_adcs");
      check("sw1_irq", 32'(ADC_Interrupt), 32'd1);
      rd_check(4'h9, 32'h02, "sw1_admsk");
      rd_check(4'hA, 32'h0, "unmapped");

      // Clear IF, then trigger a two-cell sequence.
      wr(4'h8, 32'h35);
      rd_check(4'h8, 32'h25, "w1c_adcs");
      check("w1c_irq", 32'(ADC_Interrupt), 32'd0);
      wr(4'h9, 32'h0C);
      ADC_Trigger = 1'b1;
      repeat (2) @(negedge CLK);
      ADC_Trigger = 1'b0;
      wait_cmd(5'd2, 1'b1, 1'b0, 1'b1, "trg2");
      respond(12'h123);
      wait_cmd(5'd3, 1'b0, 1'b1, 1'b1, "trg3");
      respond(12'h456);
      @(negedge CLK);
      rd_check(4'h2, 32'h123, "trg_adc2");
      rd_check(4'h3, 32'h456, "trg_adc3");
      rd_check(4'h8, 32'h35, "trg_adcs");
      check("trg_irq", 32'(ADC_Interrupt), 32'd1);

      // Free-running over cells 4 and 5 without interrupt enable.
      wr(4'h9, 32'h30);
      wr(4'h8, 32'h0B);
      wait_cmd(5'd4, 1'b1, 1'b0, 1'b1, "fr4a");
      respond(12'h400);
      wait_cmd(5'd5, 1'b0, 1'b1, 1'b1, "fr5a");
      respond(12'h500);
      wait_cmd(5'd4, 1'b1, 1'b0, 1'b1, "fr4b");
      respond(12'h401);
      wait_cmd(5'd5, 1'b0, 1'b1, 1'b1, "fr5b");
      respond(12'h501);
      wait_cmd(5'd4, 1'b1, 1'b0, 1'b0, "fr4c");
      rd_check(4'h8, 32'h1B, "fr_adcs");
      check("fr_irq", 32'(ADC_Interrupt), 32'd0);

      // Abort while a command is pending; a late response must be dropped.
      wr(4'h8, 32'h00);
      check("abort_valid", 32'(ADC_C_Valid), 32'd0);
      respond(12'hFFF);
      @(negedge CLK);
      rd_check(4'h4, 32'h401, "abort_adc4");
      rd_check(4'h5, 32'h501, "abort_adc5");
      rd_check(4'h8, 32'h10, "abort_adcs");

      // Reset in the middle of a sequence.
      wr(4'h9, 32'hFF);
      wr(4'h8, 32'h03);
      wait_cmd(5'd0, 1'b1, 1'b0, 1'b0, "rst0");
      RESET = 1'b1;
      #1;
      check("rstm_valid", 32'(ADC_C_Valid), 32'd0);
      check("rstm_ch", 32'(ADC_C_Channel), 32'd0);
      check("rstm_sop", 32'(ADC_C_SOP), 32'd0);
      check("rstm_eop", 32'(ADC_C_EOP), 32'd0);
      check("rstm_irq", 32'(ADC_Interrupt), 32'd0);
      for (int a = 0; a < 16; a++) rd_check(4'(a), 32'h0, $sformatf("rstm_reg%0d", a));
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);

      // With TE=0 a trigger pulse must not start a sequence.
      wr(4'h9, 32'h01);
      wr(4'h8, 32'h01);
      ADC_Trigger = 1'b1;
      vcount = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) ADC_Trigger = 1'b0;
         @(negedge CLK);
         if (ADC_C_Valid) vcount++;
      end
      check("te0_no_cmd", 32'(vcount), 32'd0);
      rd_check(4'h8, 32'h01, "te0_adcs");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
